// File: rtl/teras_seq_pkg.sv
// ---------------------------------------------------------------------------
// teras_seq_pkg
// Shared definitions for the teras Wishbone sequencer: register offsets
// (word index, i.e. wbs_adr_i[4:2]), CTRL/STATUS bit positions and the
// sequencer FSM state type.
// ---------------------------------------------------------------------------
package teras_seq_pkg;

    // Register offsets as word indices
    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_LEN    = 3'd2;
    localparam logic [2:0] REG_OPND   = 3'd3;
    localparam logic [2:0] REG_RES    = 3'd4;
    localparam logic [2:0] REG_CYCLES = 3'd5;

    // CTRL bit positions
    localparam int CTRL_START = 0;
    localparam int CTRL_CLEAR = 1;

    // STATUS bit positions
    localparam int STAT_BUSY       = 0;
    localparam int STAT_DONE       = 1;
    localparam int STAT_ERR        = 2;
    localparam int STAT_OPCNT_LSB  = 8;
    localparam int STAT_RESCNT_LSB = 16;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_RUN,
        SEQ_DRAIN,
        SEQ_DONE
    } seq_state_t;

    // A job is in flight while operands are streaming or results are pending
    function automatic logic is_busy(input seq_state_t s);
        return (s == SEQ_RUN) || (s == SEQ_DRAIN);
    endfunction

endpackage

// File: rtl/teras_sync_fifo.sv
// ---------------------------------------------------------------------------
// teras_sync_fifo
// Single-clock first-word-fall-through FIFO. DEPTH must be a power of two.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   flush         empties the FIFO in one cycle, overrides push/pop
//   push/push_data  write; dropped when full (even if a pop happens too)
//   pop/pop_data    pop_data shows the head word; pop ignored when empty
//   full, empty, count  occupancy
// ---------------------------------------------------------------------------
module teras_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    // Storage array has no reset so it can map onto plain memory
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/teras_wb_seq_ctrl.sv
// ---------------------------------------------------------------------------
// teras_wb_seq_ctrl
// Wishbone-slave sequencer for the teras compute datapath. The CPU fills an
// operand FIFO, programs LEN and starts a job; operands stream out on a
// valid/ready interface with a last flag and results are buffered in a
// result FIFO for readback over Wishbone.
// Ports:
//   wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//   wbs_*                       Wishbone slave (1-cycle ack, window BASE_ADDR[31:8])
//   op_valid_o/op_data_o/op_last_o/op_ready_i   operand stream to datapath
//   res_valid_i/res_data_i/res_last_i/res_ready_o  result stream from datapath
//   irq_o                       done interrupt, only when TERAS_SEQ_IRQ_EN is defined
// Optional feature macro: TERAS_SEQ_IRQ_EN
// ---------------------------------------------------------------------------
module teras_wb_seq_ctrl
    import teras_seq_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          OP_DEPTH  = 8,
    parameter int          RES_DEPTH = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        op_valid_o,
    output logic [31:0] op_data_o,
    output logic        op_last_o,
    input  logic        op_ready_i,
    input  logic        res_valid_i,
    input  logic [31:0] res_data_i,
    input  logic        res_last_i,
    output logic        res_ready_o
`ifdef TERAS_SEQ_IRQ_EN
    ,
    output logic        irq_o
`endif
);

    seq_state_t state;
    logic [15:0] len;
    logic [15:0] sent;
    logic [31:0] cycles;
    logic        err;
    logic        ready_en;
    logic [31:0] rd_data;

    logic [31:0]                    op_head;
    logic                           op_full;
    logic                           op_empty;
    logic [$clog2(OP_DEPTH):0]      op_count;
    logic [31:0]                    res_head;
    logic                           res_full;
    logic                           res_empty;
    logic [$clog2(RES_DEPTH):0]     res_count;

    logic unused_adr;
    assign unused_adr = ^{wbs_adr_i[7:5], wbs_adr_i[1:0]};

    // Bus decode: side effects happen in the request cycle, ack follows
    logic       win_hit, wb_req, wr_ok, rd_req;
    logic [2:0] reg_off;
    logic       start_cmd, clear_cmd, opnd_wr, len_wr, res_rd;
    logic       op_fire, res_fire;

    assign win_hit   = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign wb_req    = wbs_stb_i & wbs_cyc_i & win_hit & ~wbs_ack_o;
    assign reg_off   = wbs_adr_i[4:2];
    assign wr_ok     = wb_req & wbs_we_i & (wbs_sel_i == 4'hF);
    assign rd_req    = wb_req & ~wbs_we_i;
    assign start_cmd = wr_ok & (reg_off == REG_CTRL) & wbs_dat_i[CTRL_START];
    assign clear_cmd = wr_ok & (reg_off == REG_CTRL) & wbs_dat_i[CTRL_CLEAR];
    assign opnd_wr   = wr_ok & (reg_off == REG_OPND);
    assign len_wr    = wr_ok & (reg_off == REG_LEN);
    assign res_rd    = rd_req & (reg_off == REG_RES);

    assign op_valid_o  = (state == SEQ_RUN) & ~op_empty;
    assign op_data_o   = op_valid_o ? op_head : 32'd0;
    assign op_last_o   = op_valid_o & (sent == len - 16'd1);
    assign op_fire     = op_valid_o & op_ready_i;
    // ready_en holds res_ready_o low for the cycle right after reset
    assign res_ready_o = ready_en & ~res_full;
    assign res_fire    = res_valid_i & res_ready_o;

`ifdef TERAS_SEQ_IRQ_EN
    logic irq_en;
    assign irq_o = irq_en & (state == SEQ_DONE);
`endif

    teras_sync_fifo #(.DEPTH(OP_DEPTH), .WIDTH(32)) u_op_fifo (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .flush     (clear_cmd),
        .push      (opnd_wr),
        .push_data (wbs_dat_i),
        .pop       (op_fire),
        .pop_data  (op_head),
        .full      (op_full),
        .empty     (op_empty),
        .count     (op_count)
    );

    teras_sync_fifo #(.DEPTH(RES_DEPTH), .WIDTH(32)) u_res_fifo (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .flush     (clear_cmd),
        .push      (res_fire),
        .push_data (res_data_i),
        .pop       (res_rd),
        .pop_data  (res_head),
        .full      (res_full),
        .empty     (res_empty),
        .count     (res_count)
    );

    // Read mux; an empty result FIFO reads as zero
    always_comb begin
        rd_data = '0;
        case (reg_off)
`ifdef TERAS_SEQ_IRQ_EN
            REG_CTRL:   rd_data[2] = irq_en;
`endif
            REG_STATUS: begin
                rd_data[STAT_BUSY] = is_busy(state);
                rd_data[STAT_DONE] = (state == SEQ_DONE);
                rd_data[STAT_ERR]  = err;
                rd_data[STAT_OPCNT_LSB +: 4]  = 4'(op_count);
                rd_data[STAT_RESCNT_LSB +: 4] = 4'(res_count);
            end
            REG_LEN:    rd_data[15:0] = len;
            REG_RES:    rd_data = res_empty ? 32'd0 : res_head;
            REG_CYCLES: rd_data = cycles;
            default:    rd_data = '0;
        endcase
    end

    // Wishbone ack/data: single-cycle ack, data zero outside the ack cycle
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            ready_en  <= 1'b0;
        end else begin
            wbs_ack_o <= wb_req;
            wbs_dat_o <= rd_req ? rd_data : 32'd0;
            ready_en  <= 1'b1;
        end
    end

    // Sequencer FSM plus LEN, CYCLES and sticky error; clear beats start
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state  <= SEQ_IDLE;
            len    <= '0;
            sent   <= '0;
            cycles <= '0;
            err    <= 1'b0;
`ifdef TERAS_SEQ_IRQ_EN
            irq_en <= 1'b0;
`endif
        end else begin
            if (len_wr) begin
                len <= wbs_dat_i[15:0];
            end
`ifdef TERAS_SEQ_IRQ_EN
            if (wr_ok && reg_off == REG_CTRL) begin
                irq_en <= wbs_dat_i[2];
            end
`endif
            if (is_busy(state) && cycles != 32'hFFFF_FFFF) begin
                cycles <= cycles + 32'd1;
            end
            if (clear_cmd) begin
                state <= SEQ_IDLE;
                sent  <= '0;
                err   <= 1'b0;
            end else begin
                if ((opnd_wr && op_full) || (res_rd && res_empty)) begin
                    err <= 1'b1;
                end
                case (state)
                    SEQ_IDLE, SEQ_DONE: begin
                        if (start_cmd && len != 16'd0) begin
                            state  <= SEQ_RUN;
                            sent   <= '0;
                            cycles <= '0;
                        end
                    end
                    SEQ_RUN: begin
                        if (op_fire) begin
                            sent <= sent + 16'd1;
                            if (op_last_o) begin
                                state <= SEQ_DRAIN;
                            end
                        end
                    end
                    SEQ_DRAIN: begin
                        if (res_fire && res_last_i) begin
                            state <= SEQ_DONE;
                        end
                    end
                    default: state <= SEQ_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_teras_wb_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_teras_wb_seq_ctrl
// Directed bench for the teras Wishbone sequencer: reset state, a full job,
// operand overflow, result underflow and back-pressure, clear mid-run,
// stall cycle counting, reset during DRAIN and (with TERAS_SEQ_IRQ_EN) irq.
// ---------------------------------------------------------------------------
module tb_teras_wb_seq_ctrl;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [2:0] O_CTRL = 3'd0, O_STATUS = 3'd1, O_LEN = 3'd2;
    localparam logic [2:0] O_OPND = 3'd3, O_RES = 3'd4, O_CYCLES = 3'd5;

    logic        clk = 1'b0;
    logic        rst, stb, cyc, we, op_ready, res_valid, res_last;
    logic [3:0]  sel;
    logic [31:0] dat_i, adr, res_data;
    logic        ack, op_valid, op_last, res_ready;
    logic [31:0] dat_o, op_data;
`ifdef TERAS_SEQ_IRQ_EN
    logic        irq;
`endif

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    teras_wb_seq_ctrl dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wbs_stb_i   (stb),
        .wbs_cyc_i   (cyc),
        .wbs_we_i    (we),
        .wbs_sel_i   (sel),
        .wbs_dat_i   (dat_i),
        .wbs_adr_i   (adr),
        .wbs_ack_o   (ack),
        .wbs_dat_o   (dat_o),
        .op_valid_o  (op_valid),
        .op_data_o   (op_data),
        .op_last_o   (op_last),
        .op_ready_i  (op_ready),
        .res_valid_i (res_valid),
        .res_data_i  (res_data),
        .res_last_i  (res_last),
        .res_ready_o (res_ready)
`ifdef TERAS_SEQ_IRQ_EN
        ,
        .irq_o       (irq)
`endif
    );

    // Bus write; returns 1 time unit after the ack edge
    task automatic wb_write(input logic [2:0] off, input logic [31:0] data, input logic [3:0] be);
        bit got;
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b1; we = 1'b1; sel = be;
        adr = BASE | {27'd0, off, 2'b00}; dat_i = data;
        got = 1'b0;
        for (int i = 0; i < 16 && !got; i++) begin
            @(posedge clk); #1;
            if (ack === 1'b1) got = 1'b1;
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'hF;
        if (!got) begin
            checks++;
            $display("[TB] FAIL wb_write_ack: no ack for offset %0d within 16 cycles", off);
        end
    endtask

    // Bus read; data is taken in the ack cycle
    task automatic wb_read(input logic [2:0] off, output logic [31:0] data);
        bit got;
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b1; we = 1'b0; sel = 4'hF;
        adr = BASE | {27'd0, off, 2'b00};
        got = 1'b0;
        data = 32'hDEAD_BEEF;
        for (int i = 0; i < 16 && !got; i++) begin
            @(posedge clk); #1;
            if (ack === 1'b1) begin
                got = 1'b1;
                data = dat_o;
            end
        end
        stb = 1'b0; cyc = 1'b0;
        if (!got) begin
            checks++;
            $display("[TB] FAIL wb_read_ack: no ack for offset %0d within 16 cycles", off);
        end
    endtask

    // Reset values, ignored writes, zero-length start and out-of-window access
    task automatic test_reset();
        logic [31:0] rd;
        bit seen;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({ack, op_valid, op_last, res_ready} !== 4'b0000)
            $display("[TB] FAIL reset_ctrl_outs: got %b expected 0000", {ack, op_valid, op_last, res_ready}); else passes++;
        checks++; if ({dat_o, op_data} !== 64'd0)
            $display("[TB] FAIL reset_data_outs: got %h expected 0", {dat_o, op_data}); else passes++;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (res_ready !== 1'b1)
            $display("[TB] FAIL reset_res_ready: got %b expected 1", res_ready); else passes++;
        wb_read(O_STATUS, rd);
        checks++; if (rd !== 32'd0) $display("[TB] FAIL reset_status: got %h expected 0", rd); else passes++;
        wb_read(O_LEN, rd);
        checks++; if (rd !== 32'd0) $display("[TB] FAIL reset_len: got %h expected 0", rd); else passes++;
        wb_read(O_CYCLES, rd);
        checks++; if (rd !== 32'd0) $display("[TB] FAIL reset_cycles: got %h expected 0", rd); else passes++;
        wb_write(O_CTRL, 32'd1, 4'hF);
        wb_read(O_STATUS, rd);
        checks++; if (rd !== 32'd0) $display("[TB] FAIL start_len0_ignored: got %h expected 0", rd); else passes++;
        wb_write(O_LEN, 32'd5, 4'h3);
        wb_read(O_LEN, rd);
        checks++; if (rd !== 32'd0) $display("[TB] FAIL partial_sel_ignored: got %h expected 0", rd); else passes++;
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h3000_0100;
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (ack === 1'b1) seen = 1'b1;
        end
        stb = 1'b0; cyc = 1'b0;
        checks++; if (seen !== 1'b0) $display("[TB] FAIL out_of_window_ack: got %b expected 0", seen); else passes++;
    endtask

    // LEN=3 job with echo results, then readback
    task automatic test_basic_job();
        logic [31:0] rd;
        wb_write(O_LEN, 32'd3, 4'hF);
        for (int i = 0; i < 3; i++) wb_write(O_OPND, 32'hA + i, 4'hF);
        wb_read(O_STATUS, rd);
        checks++; if (rd !== 32'h0000_0300) $display("[TB] FAIL job_opcount: got %h expected 00000300", rd); else passes++;
        wb_write(O_CTRL, 32'd1, 4'hF);
        op_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if ({op_valid, op_last, op_data} !== {1'b1, (i == 2), 32'hA + i})
                $display("[TB] FAIL job_beat%0d: got v=%b l=%b d=%h expected v=1 l=%b d=%h",
                         i, op_valid, op_last, op_data, (i == 2), 32'hA + i); else passes++;
            @(posedge clk); #1;
        end
        op_ready = 1'b0;
        checks++; if (op_valid !== 1'b0) $display("[TB] FAIL job_valid_after_last: got %b expected 0", op_valid); else passes++;
        wb_read(O_STATUS, rd);
        checks++; if (rd !== 32'h0000_0001) $display("[TB] FAIL job_drain_status: got %h expected 00000001", rd); else passes++;
        for (int i = 0; i < 3; i++) begin
            res_valid = 1'b1; res_data = 32'hA + i; res_last = (i == 2);
            @(posedge clk); #1;
        end
        res_valid = 1'b0; res_last = 1'b0;
        wb_read(O_STATUS, rd);
        checks++; if (rd !== 32'h0003_0002) $display("[TB] FAIL job_done_status: got %h expected 00030002", rd); else passes++;
        for (int i = 0; i < 3; i++) begin
            wb_read(O_RES, rd);
            checks++; if (rd !== 32'hA + i) $display("[TB] FAIL job_res%0d: got %h expected %h", i, rd, 32'hA + i); else passes++;
        end
        wb_write(O_CTRL, 32'd2, 4'hF);
        wb_read(O_STATUS, rd);
        checks++; if (rd !== 32'd0) $display("[TB] FAIL job_clear_status: got %h expected 0", rd); else passes++;
    endtask

    // Ninth push into an 8-deep operand FIFO is dropped and flags err
    task automatic test_op_overflow();
        logic [31:0] rd;
        for (int i = 0; i < 9; i++) wb_write(O_OPND, 32'h50 + i, 4'hF);
        wb_read(O_STATUS, rd);
        checks++; if (rd !== 32'h0000_0804) $display("[TB] FAIL overflow_status: got %h expected 00000804", rd); else passes++;
        wb_write(O_CTRL, 32'd2, 4'hF);
    endtask

    // Empty RES read, then fill result FIFO to back-pressure and drain it
    task automatic test_res_fifo();
        logic [31:0] rd;
        logic rdy;
        int k;
        wb_read(O_RES, rd);
        checks++; if (rd !== 32'd0) $display("[TB] FAIL res_empty_data: got %h expected 0", rd); else passes++;
        wb_read(O_STATUS, rd);
        checks++; if (rd !== 32'h0000_0004) $display("[TB] FAIL res_empty_err: got %h expected 00000004", rd); else passes++;
        wb_write(O_CTRL, 32'd2, 4'hF);
        k = 0;
        for (int c = 0; c < 10; c++) begin
            res_valid = 1'b1; res_data = 32'h100 + 32'(k);
            rdy = res_ready;
            @(posedge clk); #1;
            if (rdy) k++;
        end
        res_valid = 1'b0;
        checks++; if ({res_ready, 4'(k)} !== {1'b0, 4'd8})
            $display("[TB] FAIL res_full_backpressure: got ready=%b accepted=%0d expected ready=0 accepted=8", res_ready, k); else passes++;
        wb_read(O_STATUS, rd);
        checks++; if (rd !== 32'h0008_0000) $display("[TB] FAIL res_full_status: got %h expected 00080000", rd); else passes++;
        for (int i = 0; i < 8; i++) begin
            wb_read(O_RES, rd);
            checks++; if (rd !== 32'h100 + i) $display("[TB] FAIL res_full_data%0d: got %h expected %h", i, rd, 32'h100 + i); else passes++;
        end
        wb_write(O_CTRL, 32'd2, 4'hF);
    endtask

    // Start+clear in one write while RUN returns to IDLE with FIFOs flushed
    task automatic test_clear_mid_run();
        logic [31:0] rd;
        wb_write(O_LEN, 32'd4, 4'hF);
        wb_write(O_OPND, 32'h21, 4'hF);
        wb_write(O_OPND, 32'h22, 4'hF);
        wb_write(O_CTRL, 32'd1, 4'hF);
        checks++; if (op_valid !== 1'b1) $display("[TB] FAIL clear_pre_valid: got %b expected 1", op_valid); else passes++;
        wb_write(O_CTRL, 32'd3, 4'hF);
        checks++; if (op_valid !== 1'b0) $display("[TB] FAIL clear_valid: got %b expected 0", op_valid); else passes++;
        wb_read(O_STATUS, rd);
        checks++; if (rd !== 32'd0) $display("[TB] FAIL clear_status: got %h expected 0", rd); else passes++;
        wb_read(O_LEN, rd);
        checks++; if (rd !== 32'd4) $display("[TB] FAIL clear_keeps_len: got %h expected 4", rd); else passes++;
    endtask

    // Stalled RUN keeps counting; a second start is ignored; then finish into DRAIN
    task automatic test_stall_cycles();
        logic [31:0] rd;
        wb_write(O_LEN, 32'd2, 4'hF);
        wb_write(O_OPND, 32'h11, 4'hF);
        wb_write(O_OPND, 32'h22, 4'hF);
        op_ready = 1'b0;
        wb_write(O_CTRL, 32'd1, 4'hF);
        checks++; if ({op_valid, op_last, op_data} !== {2'b10, 32'h11})
            $display("[TB] FAIL stall_head: got v=%b l=%b d=%h expected v=1 l=0 d=00000011", op_valid, op_last, op_data); else passes++;
        repeat (5) @(posedge clk);
        wb_read(O_CYCLES, rd);
        checks++; if (rd !== 32'd6) $display("[TB] FAIL stall_cycles: got %0d expected 6", rd); else passes++;
        wb_write(O_CTRL, 32'd1, 4'hF);
        wb_read(O_CYCLES, rd);
        checks++; if (rd !== 32'd10) $display("[TB] FAIL start_in_run_ignored: got %0d expected 10", rd); else passes++;
        op_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        op_ready = 1'b0;
        checks++; if (op_valid !== 1'b0) $display("[TB] FAIL stall_drain_valid: got %b expected 0", op_valid); else passes++;
        wb_read(O_STATUS, rd);
        checks++; if (rd !== 32'h0000_0001) $display("[TB] FAIL stall_drain_status: got %h expected 00000001", rd); else passes++;
    endtask

    // Reset pulse while in DRAIN drops everything back to reset values
    task automatic test_reset_in_drain();
        logic [31:0] rd;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if ({ack, op_valid, op_last, res_ready, dat_o, op_data} !== 68'd0)
            $display("[TB] FAIL drain_reset_outs: got %b %b %b %b %h %h expected all 0",
                     ack, op_valid, op_last, res_ready, dat_o, op_data); else passes++;
        rst = 1'b0;
        wb_read(O_STATUS, rd);
        checks++; if (rd !== 32'd0) $display("[TB] FAIL drain_reset_status: got %h expected 0", rd); else passes++;
        wb_read(O_LEN, rd);
        checks++; if (rd !== 32'd0) $display("[TB] FAIL drain_reset_len: got %h expected 0", rd); else passes++;
    endtask

`ifdef TERAS_SEQ_IRQ_EN
    // irq follows done while CTRL.bit2 is set; clear drops it
    task automatic test_irq();
        logic [31:0] rd;
        wb_write(O_LEN, 32'd1, 4'hF);
        wb_write(O_OPND, 32'h55, 4'hF);
        wb_write(O_CTRL, 32'd5, 4'hF);
        op_ready = 1'b1;
        @(posedge clk); #1;
        op_ready = 1'b0;
        checks++; if (irq !== 1'b0) $display("[TB] FAIL irq_before_done: got %b expected 0", irq); else passes++;
        res_valid = 1'b1; res_last = 1'b1; res_data = 32'h55;
        @(posedge clk); #1;
        res_valid = 1'b0; res_last = 1'b0;
        checks++; if (irq !== 1'b1) $display("[TB] FAIL irq_at_done: got %b expected 1", irq); else passes++;
        wb_read(O_CTRL, rd);
        checks++; if (rd !== 32'h4) $display("[TB] FAIL irq_ctrl_read: got %h expected 4", rd); else passes++;
        wb_write(O_CTRL, 32'd6, 4'hF);
        checks++; if (irq !== 1'b0) $display("[TB] FAIL irq_after_clear: got %b expected 0", irq); else passes++;
    endtask
`endif

    initial begin
        rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'hF;
        dat_i = '0; adr = '0; op_ready = 1'b0;
        res_valid = 1'b0; res_data = '0; res_last = 1'b0;
        test_reset();
        test_basic_job();
        test_op_overflow();
        test_res_fifo();
        test_clear_mid_run();
        test_stall_cycles();
        test_reset_in_drain();
`ifdef TERAS_SEQ_IRQ_EN
        test_irq();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
